// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder step per clock, LSB first.
// Result is published only when the final bit is processed.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_next;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic fa_sum;
   logic fa_cout;
   logic load;
   logic step;
   logic last;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign r_next = {fa_sum, r_sr[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands are frozen once loaded; start is only honoured in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         r_sr     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else if (load) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         carry <= cin_in;
         cnt   <= '0;
      end else if (step) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         r_sr  <= r_next;
         carry <= fa_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum_out  <= r_next;
            cout_out <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
// Expected values are hand-computed constants.

module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         cin_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout_out;

   int checks = 0;
   int fails  = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full operation; operands are scrambled after capture.
   task automatic run_op(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c,
                         input logic [W-1:0] held,
                         input logic [W-1:0] es,
                         input logic ec);
      a_in   = a;
      b_in   = b;
      cin_in = c;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      a_in   = ~a;
      b_in   = ~b;
      cin_in = ~c;
      for (int i = 0; i < W; i++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         chk({tag, "_hold"}, 32'(sum_out), 32'(held));
         tick();
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_dbusy"}, 32'(busy), 32'd0);
      chk({tag, "_sum"}, 32'(sum_out), 32'(es));
      chk({tag, "_cout"}, 32'(cout_out), 32'(ec));
      tick();
      chk({tag, "_idle"}, 32'(done), 32'd0);
      chk({tag, "_keep"}, 32'(sum_out), 32'(es));
   endtask

   int ndone;
   int last_k;

   initial begin
      rst = 1'b1;
      start = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      start = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_cout", 32'(cout_out), 32'd0);
      tick();
      chk("idle_hold", 32'(busy), 32'd0);

      run_op("t5a", 8'h5A, 8'h33, 1'b0, 8'h00, 8'h8D, 1'b0);
      run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h8D, 8'h00, 1'b1);
      run_op("max", 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1);
      run_op("zero", 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0);

      // Restart attempt during RUN must be ignored.
      a_in = 8'h10;
      b_in = 8'h01;
      cin_in = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a_in = 8'hAA;
      b_in = 8'h55;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 16; i++) begin
         if (done) begin
            ndone++;
            chk("ign_sum", 32'(sum_out), 32'h11);
            chk("ign_cout", 32'(cout_out), 32'd0);
         end
         tick();
      end
      chk("ign_ndone", 32'(ndone), 32'd1);

      // Reset in the middle of RUN aborts silently.
      a_in = 8'h80;
      b_in = 8'h81;
      cin_in = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum_out), 32'd0);
      chk("abort_cout", 32'(cout_out), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("abort_nodone", 32'(ndone), 32'd0);
      run_op("fresh", 8'h80, 8'h81, 1'b1, 8'h00, 8'h02, 1'b1);

      // Start held high: one result every WIDTH+2 cycles.
      a_in = 8'h01;
      b_in = 8'h01;
      cin_in = 1'b0;
      start = 1'b1;
      ndone = 0;
      last_k = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (done) begin
            ndone++;
            chk("b2b_sum", 32'(sum_out), 32'h02);
            chk("b2b_cout", 32'(cout_out), 32'd0);
            if (last_k >= 0)
               chk("b2b_gap", 32'(k - last_k), 32'd10);
            else
               chk("b2b_first", 32'(k), 32'd9);
            last_k = k;
         end
      end
      start = 1'b0;
      chk("b2b_count", 32'(ndone), 32'd3);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
